// File: rtl/multi_div_8bit.sv
`default_nettype none
// ============================================================================
//  Module   : multi_div_8bit
//  Brief    : Sequential signed 8-bit restoring divider, one quotient bit per
//             clock, with start/ready handshake and div-by-zero/overflow flags.
//  Revision : 1.0  initial release
// ============================================================================
module multi_div_8bit (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] q,
    output logic [7:0] r,
    output logic       rdy,
    output logic       busy,
    output logic       dz,
    output logic       ovf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t     r_state;
    logic       r_sign_q;
    logic       r_sign_r;
    logic       r_ovf_case;
    logic [7:0] r_dvd;      // dividend magnitude, becomes quotient magnitude
    logic [7:0] r_bmag;
    logic [8:0] r_rem;
    logic [2:0] r_cnt;

    logic [7:0] w_amag;
    logic [7:0] w_bmag;
    logic [9:0] w_shift;
    logic [9:0] w_trial;
    logic       w_ge;
    logic [7:0] w_qsgn;
    logic [7:0] w_rsgn;
    logic       w_accept;

    assign w_amag   = a[7] ? (8'd0 - a) : a;
    assign w_bmag   = b[7] ? (8'd0 - b) : b;
    assign w_shift  = {r_rem, r_dvd[7]};
    assign w_trial  = w_shift - {2'b00, r_bmag};
    assign w_ge     = ~w_trial[9];
    assign w_qsgn   = r_sign_q ? (8'd0 - r_dvd) : r_dvd;
    assign w_rsgn   = r_sign_r ? (8'd0 - r_rem[7:0]) : r_rem[7:0];
    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_sign_q   <= 1'b0;
            r_sign_r   <= 1'b0;
            r_ovf_case <= 1'b0;
            r_dvd      <= 8'd0;
            r_bmag     <= 8'd0;
            r_rem      <= 9'd0;
            r_cnt      <= 3'd0;
            q          <= 8'd0;
            r          <= 8'd0;
            rdy        <= 1'b0;
            busy       <= 1'b0;
            dz         <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        rdy        <= 1'b0;
                        dz         <= 1'b0;
                        ovf        <= 1'b0;
                        r_sign_q   <= a[7] ^ b[7];
                        r_sign_r   <= a[7];
                        r_ovf_case <= (a == 8'h80) && (b == 8'hFF);
                        r_dvd      <= w_amag;
                        r_bmag     <= w_bmag;
                        r_rem      <= 9'd0;
                        r_cnt      <= 3'd0;
                        if (b == 8'd0) begin
                            // Zero divisor resolves at the accept edge itself.
                            q       <= 8'hFF;
                            r       <= a;
                            dz      <= 1'b1;
                            rdy     <= 1'b1;
                            busy    <= 1'b0;
                            r_state <= S_DONE;
                        end else begin
                            busy    <= 1'b1;
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_rem <= w_ge ? w_trial[8:0] : w_shift[8:0];
                    r_dvd <= {r_dvd[6:0], w_ge};
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (r_ovf_case) begin
                        q   <= 8'h80;
                        r   <= 8'd0;
                        ovf <= 1'b1;
                    end else begin
                        q <= w_qsgn;
                        r <= w_rsgn;
                    end
                    rdy     <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
